// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// Also imported by uart_tx, so keep the encoding stable.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DBIT_DEF   = 8;
  localparam int SB_TCK_DEF = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handoff: dout/rx_valid held until rx_ack, plus a done pulse and sticky error flags.
// The receiver drives the master side; the consumer returns rx_ack through the slave side.
interface uart_rx_if;

  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_done_tck;
  logic       frame_err;
  logic       overrun;

  modport master (
    output dout,
    output rx_valid,
    output rx_done_tck,
    output frame_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  dout,
    input  rx_valid,
    input  rx_done_tck,
    input  frame_err,
    input  overrun,
    output rx_ack
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; 2 clk latency.
// Resets to 1 so an idle-high line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first; byte presented 1 clk after the stop-bit sample.
// No stall: a good frame landing on unacknowledged data is dropped and flagged as overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int SB_tck = SB_TCK_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  input  logic      s_tck,
  uart_rx_if.master bus
);

  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
  localparam logic [3:0] SB_LAST = 4'(SB_tck - 1);

  logic        rx_s;
  uart_state_t state_q, state_d;
  logic [3:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (bus.rx_ack) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tck) begin
          if (s_q == 4'd7) begin
            // Mid start bit: a line that has gone high again was only a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tck) begin
          if (s_q == 4'd15) begin
            b_d = {rx_s, b_q[7:1]};
            s_d = '0;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tck) begin
          if (s_q == SB_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (rx_s) begin
              // A same-cycle ack frees the holding slot, so the load wins.
              if (valid_q && !bus.rx_ack) begin
                ovr_d = 1'b1;
              end else begin
                dout_d  = 8'(b_q >> (8 - DBIT));
                valid_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout        = dout_q;
  assign bus.rx_valid    = valid_q;
  assign bus.rx_done_tck = done_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (8-bit and 7-bit instances) with a per-instance expectation queue.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] dout;
    logic       vld;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic rx7 = 1'b1;
  logic s_tck = 1'b0;

  int total = 0;
  int bad = 0;
  int done8 = 0;
  int done7 = 0;
  int div = 0;
  int base8 = 0;
  int base7 = 0;

  exp_t q8[$];
  exp_t q7[$];

  uart_rx_if bus8 ();
  uart_rx_if bus7 ();

  uart_rx #(.DBIT(8), .SB_tck(16)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .s_tck   (s_tck),
    .bus     (bus8)
  );

  uart_rx #(.DBIT(7), .SB_tck(16)) dut7 (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx7),
    .s_tck   (s_tck),
    .bus     (bus7)
  );

  always #5 clk = ~clk;

  // s_tck: one clk high every 4 clks, changed on the falling edge.
  always @(negedge clk) begin
    div   = (div == 3) ? 0 : div + 1;
    s_tck = (div == 0);
  end

  function automatic exp_t mk(input logic [7:0] d, input logic v, input logic f, input logic o);
    exp_t e;
    e.dout = d;
    e.vld  = v;
    e.fe   = f;
    e.ov   = o;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every done pulse pops the oldest expectation for that instance and checks the outputs.
  always @(negedge clk) begin
    exp_t e8;
    exp_t e7;
    if (bus8.rx_done_tck === 1'b1) begin
      done8++;
      total++;
      assert (q8.size() != 0) else begin
        bad++;
        $error("FAIL dut8_unexpected_done: got done pulse want none");
      end
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("dut8_dout",      32'(bus8.dout),      32'(e8.dout));
        check("dut8_rx_valid",  32'(bus8.rx_valid),  32'(e8.vld));
        check("dut8_frame_err", 32'(bus8.frame_err), 32'(e8.fe));
        check("dut8_overrun",   32'(bus8.overrun),   32'(e8.ov));
      end
    end
    if (bus7.rx_done_tck === 1'b1) begin
      done7++;
      total++;
      assert (q7.size() != 0) else begin
        bad++;
        $error("FAIL dut7_unexpected_done: got done pulse want none");
      end
      if (q7.size() != 0) begin
        e7 = q7.pop_front();
        check("dut7_dout",      32'(bus7.dout),      32'(e7.dout));
        check("dut7_rx_valid",  32'(bus7.rx_valid),  32'(e7.vld));
        check("dut7_frame_err", 32'(bus7.frame_err), 32'(e7.fe));
        check("dut7_overrun",   32'(bus7.overrun),   32'(e7.ov));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(5);
  endtask

  // Drives one frame cycle by cycle. The receiver enters START three clks after the falling
  // edge, so ticks are counted from there; the stop sample lands on tick 8 + 16*(nb+1).
  task automatic send(input logic [7:0] d, input int nb, input logic stopv, input bit on7,
                      input bit ack_load, input int rst_at);
    int   tick;
    logic v;
    tick = 0;
    for (int k = 0; k < (nb + 2) * 64; k++) begin
      @(negedge clk);
      #1;
      if (k < 64)                 v = 1'b0;
      else if (k < (nb + 1) * 64) v = d[k / 64 - 1];
      else                        v = stopv;
      if (on7) rx7 = v;
      else     rx  = v;
      if (k >= 3 && s_tck) tick++;
      if (ack_load) bus8.rx_ack = (k >= 3 && s_tck && tick == 8 + 16 * (nb + 1));
      if (rst_at >= 0) reset_n = !(k >= rst_at && k < rst_at + 3);
    end
    rx  = 1'b1;
    rx7 = 1'b1;
    if (ack_load) bus8.rx_ack = 1'b0;
  endtask

  initial begin
    bus8.rx_ack = 1'b0;
    bus7.rx_ack = 1'b0;
    idle(3);

    check("rst_dout",        32'(bus8.dout),        32'h00);
    check("rst_rx_valid",    32'(bus8.rx_valid),    32'h0);
    check("rst_rx_done_tck", 32'(bus8.rx_done_tck), 32'h0);
    check("rst_frame_err",   32'(bus8.frame_err),   32'h0);
    check("rst_overrun",     32'(bus8.overrun),     32'h0);
    check("rst7_dout",       32'(bus7.dout),        32'h00);
    check("rst7_rx_valid",   32'(bus7.rx_valid),    32'h0);
    reset_n = 1'b1;
    idle(10);

    // Good 0x55 frame, then acknowledge it.
    base8 = done8;
    q8.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0));
    send(8'h55, 8, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    check("f55_done_count", 32'(done8 - base8), 32'd1);
    check("f55_valid_held", 32'(bus8.rx_valid), 32'h1);
    bus8.rx_ack = 1'b1;
    idle(1);
    bus8.rx_ack = 1'b0;
    idle(1);
    check("ack_clears_valid", 32'(bus8.rx_valid), 32'h0);
    check("ack_keeps_dout",   32'(bus8.dout),     32'h55);

    // Start-bit glitch: low for 4 ticks only.
    base8 = done8;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(100);
    check("glitch_state",      32'(dut8.state_q),   32'(IDLE));
    check("glitch_no_done",    32'(done8 - base8),  32'd0);
    check("glitch_valid",      32'(bus8.rx_valid),  32'h0);
    check("glitch_frame_err",  32'(bus8.frame_err), 32'h0);

    // 0xA3 with a low stop bit.
    do_reset();
    base8 = done8;
    q8.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
    send(8'hA3, 8, 1'b0, 1'b0, 1'b0, -1);
    idle(10);
    check("ferr_done_count", 32'(done8 - base8), 32'd1);
    idle(50);
    check("ferr_sticky", 32'(bus8.frame_err), 32'h1);

    // Overrun: 0x11 then 0x22 without ack.
    do_reset();
    q8.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0));
    send(8'h11, 8, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    q8.push_back(mk(8'h11, 1'b1, 1'b0, 1'b1));
    send(8'h22, 8, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    check("ovr_dout", 32'(bus8.dout),    32'h11);
    check("ovr_flag", 32'(bus8.overrun), 32'h1);

    // Same pair, ack coinciding with the 0x22 load cycle.
    do_reset();
    q8.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0));
    send(8'h11, 8, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    q8.push_back(mk(8'h22, 1'b1, 1'b0, 1'b0));
    send(8'h22, 8, 1'b1, 1'b0, 1'b1, -1);
    idle(10);
    check("ackload_dout",  32'(bus8.dout),     32'h22);
    check("ackload_ovr",   32'(bus8.overrun),  32'h0);
    check("ackload_valid", 32'(bus8.rx_valid), 32'h1);

    // Reset during data bit 4 of 0xF0, then a full 0x3C.
    base8 = done8;
    send(8'hF0, 8, 1'b1, 1'b0, 1'b0, 340);
    idle(10);
    check("midrst_no_done", 32'(done8 - base8), 32'd0);
    check("midrst_valid",   32'(bus8.rx_valid), 32'h0);
    q8.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
    send(8'h3C, 8, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    check("midrst_done_count", 32'(done8 - base8), 32'd1);
    check("midrst_dout",       32'(bus8.dout),     32'h3C);

    // 7-bit instance receives 0x5A.
    base7 = done7;
    base8 = done8;
    q7.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0));
    send(8'h5A, 7, 1'b1, 1'b1, 1'b0, -1);
    idle(10);
    check("d7_done_count", 32'(done7 - base7), 32'd1);
    check("d7_dout_msb",   32'(bus7.dout[7]),  32'h0);
    check("d7_dut8_quiet", 32'(done8 - base8), 32'd0);

    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q7_drained", 32'(q7.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
